reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port successor to the core's 32x32 register file.
- Configurable data width, register count, read-port count and write-port count.
- Optional write-to-read bypass and optional hardwired-zero register.
- Integrated busy scoreboard: the pipeline reserves a destination register at issue, and the busy bit clears on writeback, giving hazard detection without extra logic in the core.

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers; must be a power of two and >= 2.
- NUM_RD, 2, number of combinational read ports (1..4).
- NUM_WR, 1, number of write ports (1..2).
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read data; 0 = reads return the stored value.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy.
- (localparam) AW, $clog2(NUM_REGS), register index width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  NUM_WR  per-port write enable.
- wr_reg  in  NUM_WR x AW  per-port write index.
- wr_data  in  NUM_WR x XLEN  per-port write data.
- rd_reg  in  NUM_RD x AW  per-port read index.
- rd_data  out  NUM_RD x XLEN  per-port read data (combinational).
- rsv_en  in  1  reserve-destination strobe from issue.
- rsv_reg  in  AW  register index to mark busy.
- rd_busy  out  NUM_RD  busy status of the register addressed by each read port.
- any_busy  out  1  OR of all busy bits.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers clear to 0 and all busy bits clear.
  - rd_data = 0, rd_busy = 0, any_busy = 0 for the whole time reset is asserted.
  - A write or reservation presented in the cycle reset deasserts takes effect at the next rising edge only.
- Write (rising edge):
  - For each port i with wr_en[i]=1, reg[wr_reg[i]] <= wr_data[i].
  - With ZERO_REG=1, a write to index 0 is discarded.
  - Two ports writing the same index in one cycle: the highest-index port wins.
- Read (combinational, zero-cycle latency):
  - ZERO_REG=1 and rd_reg[j]=0 -> rd_data[j]=0, regardless of bypass.
  - Otherwise, with BYPASS=1: if any enabled write port targets rd_reg[j] this cycle, rd_data[j] = that port's wr_data; the highest-index port wins if several match.
  - Otherwise rd_data[j] = reg[rd_reg[j]] (old value until the edge).
- Scoreboard (rising edge):
  - rsv_en=1 sets busy[rsv_reg].
  - Each effective write clears busy[wr_reg[i]].
  - Reserve and write to the same index in one cycle: the set wins, because the new reservation is the younger instruction.
  - rsv_reg=0 with ZERO_REG=1 is ignored.
  - Reserving an already-busy register leaves it busy; there is no count.
- rd_busy[j]:
  - rd_busy[j] = busy[rd_reg[j]], forced 0 for index 0 when ZERO_REG=1.
  - With BYPASS=1 it is also forced 0 when an enabled write targets rd_reg[j] this cycle, since the data is already forwarded.
- any_busy:
  - Registered OR of the busy vector after the edge; no combinational path from inputs.
- Index wrap: indexes are AW bits wide, so out-of-range values are impossible; no checking is needed.
- Storage: flops, not inferred RAM, so that multi-port reads and the asynchronous clear are legal.

Decomposition:
- Package reg_file_mp_pkg holds:
  - default parameter constants (XLEN_DEF, NUM_REGS_DEF);
  - typedef reg_idx_t (logic [AW-1:0] for the default configuration);
  - typedef reg_data_t;
  - a write-port struct {en, idx, data} used by the bench transaction.
- One sub-module: reg_file_scoreboard.
  - Parameters NUM_REGS, NUM_WR, NUM_RD, ZERO_REG.
  - Owns the busy vector, any_busy and the set/clear priority.
  - The top level owns storage and the read/bypass muxing.

Test Plan:
- Reset mid-run: write 32'hDEADBEEF to x5, assert rst_n low between edges -> rd_data for x5 reads 0 immediately; busy=0; any_busy=0.
- Bypass: BYPASS=1, in the same cycle write x7=32'h1234_5678 and read x7 on both ports -> both return 32'h1234_5678 before the edge. With BYPASS=0 -> old value 0, then 32'h1234_5678 after the edge.
- x0 protection: ZERO_REG=1, write x0=32'hFFFFFFFF and rsv_reg=0 -> x0 reads 0 and rd_busy=0 on all later cycles.
- Write-port collision: NUM_WR=2, port0 writes x3=32'hAAAA_AAAA and port1 writes x3=32'h5555_5555 -> stored and bypassed value is 32'h5555_5555.
- Scoreboard ordering:
  - Reserve x9 in cycle N -> rd_busy=1 on x9 from N+1.
  - Write x9 plus reserve x9 in cycle N+3 -> x9 still busy.
  - Write x9 alone in N+4 -> x9 not busy from N+5; any_busy=0.
- Randomised 1000-transaction run against a parametrised reference model for NUM_RD=4, NUM_WR=2 -> zero mismatches; coverage of every index on every port plus collision and bypass bins.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// Shared types and default sizing for the multi-port register file.
package reg_file_mp_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int AW_DEF       = $clog2(NUM_REGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_idx_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;

  // One write port as seen by a transaction: enable, target index, data.
  typedef struct packed {
    logic      en;
    reg_idx_t  idx;
    reg_data_t data;
  } wr_port_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Busy scoreboard: issue reserves a destination, writeback releases it.
// A reservation landing in the same cycle as a write to that index wins,
// because the reservation belongs to the younger instruction.
module reg_file_scoreboard
  import reg_file_mp_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_WR   = 1,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR-1:0][AW-1:0] wr_reg,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_reg,
  input  logic [NUM_RD-1:0][AW-1:0] rd_reg,
  input  logic [NUM_RD-1:0]        rd_fwd,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     any_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                any_busy_q;
  logic                rsv_eff;

  // Next busy vector: writebacks clear first, then the reservation sets.
  always_comb begin
    busy_d  = busy_q;
    rsv_eff = rsv_en & ~(ZERO_REG & (rsv_reg == {AW{1'b0}}));
    for (int i = 0; i < NUM_WR; i++) begin
      busy_d[wr_reg[i]] = (wr_en[i] & ~(ZERO_REG & (wr_reg[i] == {AW{1'b0}})))
                          ? 1'b0 : busy_d[wr_reg[i]];
    end
    busy_d[rsv_reg] = rsv_eff ? 1'b1 : busy_d[rsv_reg];
    busy_d[0]       = ZERO_REG ? 1'b0 : busy_d[0];
  end

  // Busy state and its registered OR-reduction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= {NUM_REGS{1'b0}};
      any_busy_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      any_busy_q <= |busy_d;
    end
  end

  // Per-port busy lookup; a forwarded write means the data is already here.
  always_comb begin
    for (int j = 0; j < NUM_RD; j++) begin
      if (!rst_n || (ZERO_REG && (rd_reg[j] == {AW{1'b0}})) || rd_fwd[j]) begin
        rd_busy[j] = 1'b0;
      end else begin
        rd_busy[j] = busy_q[rd_reg[j]];
      end
    end
  end

  assign any_busy = any_busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with optional write-to-read bypass,
// optional hardwired-zero register and an integrated busy scoreboard.
// Storage is flops so all read ports and the asynchronous clear are legal.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]  wr_reg,
  input  logic [NUM_WR-1:0][XLEN-1:0] wr_data,
  input  logic [NUM_RD-1:0][AW-1:0]  rd_reg,
  output logic [NUM_RD-1:0][XLEN-1:0] rd_data,
  input  logic                       rsv_en,
  input  logic [AW-1:0]              rsv_reg,
  output logic [NUM_RD-1:0]          rd_busy,
  output logic                       any_busy
);

  logic [NUM_REGS-1:0][XLEN-1:0] regs_q;
  logic [NUM_REGS-1:0][XLEN-1:0] regs_d;
  logic [NUM_RD-1:0]             fwd_hit;
  logic [NUM_RD-1:0][XLEN-1:0]   fwd_data;

  // Next storage: ports applied in ascending order so the highest port wins.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_WR; i++) begin
      regs_d[wr_reg[i]] = (wr_en[i] & ~(ZERO_REG & (wr_reg[i] == {AW{1'b0}})))
                          ? wr_data[i] : regs_d[wr_reg[i]];
    end
  end

  // Register storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= {(NUM_REGS*XLEN){1'b0}};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass match per read port; later write ports override earlier ones.
  always_comb begin
    for (int j = 0; j < NUM_RD; j++) begin
      fwd_hit[j]  = 1'b0;
      fwd_data[j] = {XLEN{1'b0}};
      for (int i = 0; i < NUM_WR; i++) begin
        fwd_hit[j]  = (BYPASS && wr_en[i] && (wr_reg[i] == rd_reg[j])) ? 1'b1 : fwd_hit[j];
        fwd_data[j] = (BYPASS && wr_en[i] && (wr_reg[i] == rd_reg[j])) ? wr_data[i] : fwd_data[j];
      end
    end
  end

  // Read mux: reset and x0 force zero, then forwarded data, then storage.
  always_comb begin
    for (int j = 0; j < NUM_RD; j++) begin
      if (!rst_n || (ZERO_REG && (rd_reg[j] == {AW{1'b0}}))) begin
        rd_data[j] = {XLEN{1'b0}};
      end else if (fwd_hit[j]) begin
        rd_data[j] = fwd_data[j];
      end else begin
        rd_data[j] = regs_q[rd_reg[j]];
      end
    end
  end

  reg_file_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_reg   (wr_reg),
    .rsv_en   (rsv_en),
    .rsv_reg  (rsv_reg),
    .rd_reg   (rd_reg),
    .rd_fwd   (fwd_hit),
    .rd_busy  (rd_busy),
    .any_busy (any_busy)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench: two instances share stimulus, A = bypass + x0 hardwired,
// B = no bypass, x0 writable. A reference model predicts every cycle's reads.
module tb_reg_file_mp;
  import reg_file_mp_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic [1:0]           wr_en;
  logic [1:0][4:0]      wr_reg;
  logic [1:0][31:0]     wr_data;
  logic [3:0][4:0]      rd_reg;
  logic                 rsv_en;
  logic [4:0]           rsv_reg;
  logic [3:0][31:0]     rd_data_a, rd_data_b;
  logic [3:0]           rd_busy_a, rd_busy_b;
  logic                 any_busy_a, any_busy_b;

  reg_file_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD(4), .NUM_WR(2),
                .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_reg(rd_reg), .rd_data(rd_data_a), .rsv_en(rsv_en), .rsv_reg(rsv_reg),
    .rd_busy(rd_busy_a), .any_busy(any_busy_a));

  reg_file_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD(4), .NUM_WR(2),
                .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_reg(rd_reg), .rd_data(rd_data_b), .rsv_en(rsv_en), .rsv_reg(rsv_reg),
    .rd_busy(rd_busy_b), .any_busy(any_busy_b));

  typedef struct packed {
    logic [1:0][3:0][31:0] d;
    logic [1:0][3:0]       b;
    logic [1:0]            a;
  } exp_t;

  exp_t        expq[$];
  int          nchk = 0;
  int          nerr = 0;
  logic [31:0] mregs [2][32];
  logic        mbusy [2][32];
  logic        many  [2];
  bit          cov_idx [4][32];
  int          cov_coll = 0;
  int          cov_byp  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic wr_port_t wp(input logic en, input logic [4:0] idx, input logic [31:0] d);
    wr_port_t w;
    w.en = en; w.idx = idx; w.data = d;
    return w;
  endfunction

  function automatic logic [3:0][4:0] rr4(input logic [4:0] a, input logic [4:0] b,
                                          input logic [4:0] c, input logic [4:0] d);
    return {d, c, b, a};
  endfunction

  // One cycle: drive inputs after the edge, predict outputs, advance the model.
  task automatic drive(input logic rst, input wr_port_t w0, input wr_port_t w1,
                       input logic [3:0][4:0] rr, input logic rv, input logic [4:0] rvr);
    exp_t     e;
    wr_port_t w [2];
    bit       bp, zr, hit;
    logic [31:0] fwd;
    @(posedge clk); #1;
    rst_n   = rst;
    wr_en   = {w1.en, w0.en};
    wr_reg  = {w1.idx, w0.idx};
    wr_data = {w1.data, w0.data};
    rd_reg  = rr;
    rsv_en  = rv;
    rsv_reg = rvr;
    w[0] = w0; w[1] = w1;
    e = '0;
    for (int c = 0; c < 2; c++) begin
      bp = (c == 0); zr = (c == 0);
      for (int j = 0; j < 4; j++) begin
        hit = 1'b0; fwd = 32'd0;
        for (int i = 0; i < 2; i++)
          if (w[i].en && w[i].idx == rr[j]) begin hit = 1'b1; fwd = w[i].data; end
        if (!rst)                         begin e.d[c][j] = 32'd0;          e.b[c][j] = 1'b0; end
        else if (zr && rr[j] == 5'd0)     begin e.d[c][j] = 32'd0;          e.b[c][j] = 1'b0; end
        else if (bp && hit)               begin e.d[c][j] = fwd;            e.b[c][j] = 1'b0; end
        else                              begin e.d[c][j] = mregs[c][rr[j]]; e.b[c][j] = mbusy[c][rr[j]]; end
      end
      e.a[c] = rst ? many[c] : 1'b0;
    end
    expq.push_back(e);
    for (int c = 0; c < 2; c++) begin
      zr = (c == 0);
      if (!rst) begin
        for (int k = 0; k < 32; k++) begin mregs[c][k] = 32'd0; mbusy[c][k] = 1'b0; end
        many[c] = 1'b0;
      end else begin
        for (int i = 0; i < 2; i++)
          if (w[i].en && !(zr && w[i].idx == 5'd0)) begin
            mregs[c][w[i].idx] = w[i].data;
            mbusy[c][w[i].idx] = 1'b0;
          end
        if (rv && !(zr && rvr == 5'd0)) mbusy[c][rvr] = 1'b1;
        many[c] = 1'b0;
        for (int k = 0; k < 32; k++) many[c] = many[c] | mbusy[c][k];
      end
    end
  endtask

  // Monitor: pops one prediction per cycle and compares mid-cycle.
  initial begin
    exp_t e;
    logic [1:0][3:0][31:0] ad;
    logic [1:0][3:0]       ab;
    logic [1:0]            aa;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        ad[0] = rd_data_a; ad[1] = rd_data_b;
        ab[0] = rd_busy_a; ab[1] = rd_busy_b;
        aa[0] = any_busy_a; aa[1] = any_busy_b;
        for (int c = 0; c < 2; c++) begin
          for (int j = 0; j < 4; j++) begin
            nchk++;
            if (ad[c][j] !== e.d[c][j]) begin
              nerr++;
              $display("FAIL rd_data dut%0d port%0d @%0t: got %h expected %h",
                       c, j, $time, ad[c][j], e.d[c][j]);
            end
          end
          nchk++;
          if (ab[c] !== e.b[c]) begin
            nerr++;
            $display("FAIL rd_busy dut%0d @%0t: got %b expected %b", c, $time, ab[c], e.b[c]);
          end
          nchk++;
          if (aa[c] !== e.a[c]) begin
            nerr++;
            $display("FAIL any_busy dut%0d @%0t: got %b expected %b", c, $time, aa[c], e.a[c]);
          end
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    wr_port_t nop, w0, w1;
    logic [3:0][4:0] rr;
    int covered;
    nop = wp(1'b0, 5'd0, 32'd0);
    rst_n = 1'b0; wr_en = 2'b00; wr_reg = '0; wr_data = '0;
    rd_reg = '0; rsv_en = 1'b0; rsv_reg = 5'd0;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 32; k++) begin mregs[c][k] = 32'd0; mbusy[c][k] = 1'b0; end
      many[c] = 1'b0;
    end

    // Reset with live inputs: everything must read zero.
    drive(1'b0, nop, nop, rr4(0, 1, 2, 3), 1'b0, 5'd0);
    drive(1'b0, wp(1'b1, 5'd5, 32'hDEADBEEF), nop, rr4(5, 5, 5, 5), 1'b1, 5'd5);
    // Write presented as reset releases lands at the next edge.
    drive(1'b1, wp(1'b1, 5'd5, 32'hDEADBEEF), nop, rr4(5, 5, 6, 6), 1'b1, 5'd6);
    drive(1'b1, nop, nop, rr4(5, 6, 5, 6), 1'b0, 5'd0);
    // Reset mid-run.
    drive(1'b0, nop, nop, rr4(5, 6, 5, 6), 1'b0, 5'd0);
    drive(1'b1, nop, nop, rr4(5, 6, 5, 6), 1'b0, 5'd0);

    // Bypass vs stored value.
    drive(1'b1, wp(1'b1, 5'd7, 32'h1234_5678), nop, rr4(7, 7, 7, 7), 1'b0, 5'd0);
    drive(1'b1, nop, nop, rr4(7, 7, 7, 7), 1'b0, 5'd0);

    // x0 write and reservation.
    drive(1'b1, wp(1'b1, 5'd0, 32'hFFFF_FFFF), wp(1'b1, 5'd0, 32'hFFFF_FFFF),
          rr4(0, 0, 0, 0), 1'b1, 5'd0);
    drive(1'b1, nop, nop, rr4(0, 0, 7, 0), 1'b0, 5'd0);
    drive(1'b1, nop, nop, rr4(0, 0, 0, 0), 1'b0, 5'd0);

    // Write-port collision.
    drive(1'b1, wp(1'b1, 5'd3, 32'hAAAA_AAAA), wp(1'b1, 5'd3, 32'h5555_5555),
          rr4(3, 3, 3, 3), 1'b0, 5'd0);
    drive(1'b1, nop, nop, rr4(3, 3, 3, 3), 1'b0, 5'd0);

    // Scoreboard ordering on x9.
    drive(1'b1, nop, nop, rr4(9, 9, 9, 9), 1'b1, 5'd9);
    drive(1'b1, nop, nop, rr4(9, 9, 9, 9), 1'b0, 5'd0);
    drive(1'b1, nop, nop, rr4(9, 9, 9, 9), 1'b0, 5'd0);
    drive(1'b1, wp(1'b1, 5'd9, 32'h0000_0099), nop, rr4(9, 9, 9, 9), 1'b1, 5'd9);
    drive(1'b1, nop, wp(1'b1, 5'd9, 32'h0000_0999), rr4(9, 9, 9, 9), 1'b0, 5'd0);
    drive(1'b1, nop, nop, rr4(9, 9, 9, 9), 1'b0, 5'd0);
    drive(1'b1, nop, nop, rr4(9, 3, 7, 0), 1'b0, 5'd0);

    // Randomized traffic with biased collisions and bypass hits.
    for (int t = 0; t < 1000; t++) begin
      w0 = wp(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      w1 = wp(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 5) == 0) w1.idx = w0.idx;
      for (int j = 0; j < 4; j++) begin
        case ($urandom_range(0, 3))
          0:       rr[j] = w0.idx;
          1:       rr[j] = w1.idx;
          default: rr[j] = 5'($urandom_range(0, 31));
        endcase
        cov_idx[j][rr[j]] = 1'b1;
        if ((w0.en && w0.idx == rr[j]) || (w1.en && w1.idx == rr[j])) cov_byp++;
      end
      if (w0.en && w1.en && w0.idx == w1.idx) cov_coll++;
      drive(1'b1, w0, w1, rr, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end
    drive(1'b1, nop, nop, rr4(1, 2, 3, 4), 1'b0, 5'd0);

    repeat (3) @(posedge clk);
    nchk++;
    if (expq.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d pending predictions expected 0", expq.size());
    end
    covered = 0;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 32; k++)
        if (cov_idx[j][k]) covered++;
    $display("coverage: read index bins %0d/128, collisions %0d, bypass hits %0d",
             covered, cov_coll, cov_byp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
